// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the slow_memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;
  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-requester round-robin / fixed-priority owner chooser.
module rr_pick2 import mem_arb_pkg::*; (
  input  logic   req_i,
  input  logic   req_d,
  input  owner_t last_owner,
  input  logic   fixed_prio,
  output owner_t owner,
  output logic   valid
);
  assign valid = req_i | req_d;
  always_comb owner = fixed_prio ? (req_d ? OWN_D : OWN_I) :
                      (req_i && req_d) ? (last_owner == OWN_D ? OWN_I : OWN_D) :
                      (req_d ? OWN_D : OWN_I);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow_memory line port between I_cache and D_cache,
// holding each grant until mem_ready and counting completed transactions.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  grant_cnt_i,
  output logic [CNT_W-1:0]  grant_cnt_d
);
  state_t            state_q, state_d;
  owner_t            owner_q, owner_d, last_q, last_d, pick_owner;
  logic              pick_valid;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_i_q, cnt_i_d, cnt_d_q, cnt_d_d;

  rr_pick2 u_pick (
    .req_i      (i_read | i_write),
    .req_d      (d_read | d_write),
    .last_owner (last_q),
    .fixed_prio (FIXED_PRIO != 0),
    .owner      (pick_owner),
    .valid      (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_i_d = cnt_i_q;
    cnt_d_d = cnt_d_q;
    unique case (state_q)
      IDLE: if (pick_valid) begin
        state_d = BUSY;
        owner_d = pick_owner;
        // a simultaneous read+write forwards only the write
        wr_d    = pick_owner == OWN_D ? d_write : i_write;
        rd_d    = (pick_owner == OWN_D ? d_read : i_read) & ~wr_d;
        addr_d  = pick_owner == OWN_D ? d_addr : i_addr;
        wdata_d = pick_owner == OWN_D ? d_wdata : i_wdata;
      end
      BUSY: if (mem_ready) begin
        state_d = RELEASE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        last_d  = owner_q;
        cnt_i_d = owner_q == OWN_I ? cnt_i_q + {{(CNT_W-1){1'b0}}, ~&cnt_i_q} : cnt_i_q;
        cnt_d_d = owner_q == OWN_D ? cnt_d_q + {{(CNT_W-1){1'b0}}, ~&cnt_d_q} : cnt_d_q;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      last_q  <= OWN_D;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_i_q <= '0;
      cnt_d_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_i_q <= cnt_i_d;
      cnt_d_q <= cnt_d_d;
    end
  end

  assign mem_read    = rd_q;
  assign mem_write   = wr_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_ready     = mem_ready && state_q == BUSY && owner_q == OWN_I;
  assign d_ready     = mem_ready && state_q == BUSY && owner_q == OWN_D;
  assign i_rdata     = mem_rdata;
  assign d_rdata     = mem_rdata;
  assign grant_cnt_i = cnt_i_q;
  assign grant_cnt_d = cnt_d_q;
endmodule
